block_align_denorm: RTL and testbench

//   Inverse of the MAC normalization stage: converts a block of FP terms (sign, 11-bit fraction, signed exp)

---
 rtl/block_align_denorm_pkg.sv | 27 ++
 rtl/block_align_denorm_align_shifter.sv | 41 ++++
 rtl/block_align_denorm.sv | 138 +++++++++++++
 tb/tb_block_align_denorm.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/block_align_denorm_pkg.sv
// Shared definitions for the block alignment / denormalization slice.
//   MANT_W, EXP_W, ACC_W : fraction, exponent and aligned-output widths
//   SH_W                 : width of the exponent difference (one bit wider than EXP_W)
//   SIG_W                : significand width including the hidden one
//   state_t              : two-phase FSM encoding (collect a block, then emit it)
//   term_t               : one buffered FP term
package block_align_denorm_pkg;

  localparam int MANT_W = 11;
  localparam int EXP_W  = 6;
  localparam int ACC_W  = 20;
  localparam int SH_W   = EXP_W + 1;
  localparam int SIG_W  = MANT_W + 1;

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_t;

  typedef struct packed {
    logic              sign;
    logic              zero;
    logic [MANT_W-1:0] frac;
    logic [EXP_W-1:0]  exp;
  } term_t;

endpackage

// File: rtl/block_align_denorm_align_shifter.sv
// Combinational alignment of one FP term to the block maximum exponent.
// Ports:
//   sign  in   1      term sign (1 = negative)
//   zero  in   1      exact-zero term, forces a 0 result
//   frac  in   11     fraction bits below the hidden one
//   sh    in   7      exp_max - exp, never negative for a non-zero term
//   data  out  20     aligned two's-complement value
module align_shifter
  import block_align_denorm_pkg::*;
(
  input  logic              sign,
  input  logic              zero,
  input  logic [MANT_W-1:0] frac,
  input  logic [SH_W-1:0]   sh,
  output logic [ACC_W-1:0]  data
);

  logic [ACC_W-1:0] sig_ext;
  logic [ACC_W-1:0] mag;

  // Right-shift the significand (hidden one included) and truncate. Once the
  // shift reaches the significand width every bit has fallen off, so the
  // magnitude is forced to zero explicitly. Sign is applied afterwards so a
  // fully shifted-out negative term still yields +0.
  always_comb begin
    sig_ext = {{(ACC_W-SIG_W){1'b0}}, 1'b1, frac};
    if (sh >= SH_W'(SIG_W)) begin
      mag = '0;
    end else begin
      mag = sig_ext >> sh;
    end
    if (zero) begin
      data = '0;
    end else if (sign) begin
      data = -mag;
    end else begin
      data = mag;
    end
  end

endmodule

// File: rtl/block_align_denorm.sv
// Collects a block of FP terms, tracks the block's maximum exponent, then
// emits each term as a 20-bit two's-complement value aligned to that maximum.
// Ports:
//   clk        in   1    clock, rising edge
//   rst_n      in   1    asynchronous active-low reset
//   in_valid   in   1    input term valid
//   in_ready   out  1    block accepts a term this cycle
//   in_sign    in   1    term sign (1 = negative)
//   in_frac    in   11   fraction bits below the hidden one
//   in_exp     in   6    signed term exponent
//   in_zero    in   1    term is exact zero
//   in_last    in   1    closes the block early
//   out_valid  out  1    aligned term valid
//   out_ready  in   1    downstream accepts term
//   out_data   out  20   signed aligned term
//   out_exp    out  6    signed block max exponent
//   out_last   out  1    final term of the block
module block_align_denorm
  import block_align_denorm_pkg::*;
#(
  parameter int BLK_N = 4,
  parameter int CNT_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [MANT_W-1:0] in_frac,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic              in_zero,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_last
);

  localparam int IDX_W = (BLK_N > 1) ? $clog2(BLK_N) : 1;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] idx;
  logic [EXP_W-1:0] exp_max;
  logic             max_seen;
  term_t            term_buf [BLK_N];

  logic             accept;
  logic             take;
  logic             at_last;
  term_t            cur;
  logic [SH_W-1:0]  sh;
  logic [ACC_W-1:0] aligned;

  assign accept  = in_valid && in_ready;
  assign take    = out_valid && out_ready;
  assign at_last = (CNT_W'(idx) == count - CNT_W'(1));
  assign cur     = term_buf[idx];

  // Sign-extend both exponents before subtracting so the full signed range
  // of differences fits without wrap.
  assign sh = {exp_max[EXP_W-1], exp_max} - {cur.exp[EXP_W-1], cur.exp};

  align_shifter u_align (
    .sign (cur.sign),
    .zero (cur.zero),
    .frac (cur.frac),
    .sh   (sh),
    .data (aligned)
  );

  // Outside EMIT the buffer may hold stale or unwritten entries, so the data
  // output is gated to keep it at zero whenever nothing is being presented.
  assign out_data = out_valid ? aligned : '0;
  assign out_exp  = exp_max;
  assign out_last = out_valid && at_last;

  // Term storage carries no reset: count gates which entries are ever read.
  always_ff @(posedge clk) begin
    if (accept) begin
      term_buf[count[IDX_W-1:0]] <= {in_sign, in_zero, in_frac, in_exp};
    end
  end

  // Block FSM: COLLECT fills the buffer and tracks the running max exponent
  // (zero terms excluded); EMIT walks the buffer one term per handshake and
  // clears everything after the final term so the next block starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= COLLECT;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      count     <= '0;
      idx       <= '0;
      exp_max   <= '0;
      max_seen  <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            count <= count + CNT_W'(1);
            if (!in_zero && (!max_seen || ($signed(in_exp) > $signed(exp_max)))) begin
              exp_max  <= in_exp;
              max_seen <= 1'b1;
            end
            if ((count == CNT_W'(BLK_N-1)) || in_last) begin
              state     <= EMIT;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (take) begin
            if (at_last) begin
              state     <= COLLECT;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              count     <= '0;
              idx       <= '0;
              exp_max   <= '0;
              max_seen  <= 1'b0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        default: begin
          state     <= COLLECT;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_block_align_denorm.sv
// Self-checking bench for block_align_denorm: hand-built vector table,
// randomized blocks against an arithmetic reference model, backpressure,
// early-close, single-term and mid-emit reset sequences.
module tb_block_align_denorm;

  localparam int BLK_N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [10:0] in_frac = '0;
  logic [5:0]  in_exp = '0;
  logic        in_zero = 1'b0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [19:0] out_data;
  logic [5:0]  out_exp;
  logic        out_last;

  int assertCount = 0;
  int failCount = 0;

  typedef struct packed {
    logic [2:0]       n;
    logic             useLast;
    logic [3:0]       sign;
    logic [3:0]       zero;
    logic [3:0][10:0] frac;
    logic [3:0][5:0]  exp;
    logic [5:0]       expExp;
    logic [3:0][19:0] expData;
  } vec_t;

  vec_t tbl [7];

  block_align_denorm #(.BLK_N(BLK_N), .CNT_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_frac   (in_frac),
    .in_exp    (in_exp),
    .in_zero   (in_zero),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_exp   (out_exp),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  // Hard stop in case some handshake never completes.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // Value of one term scaled so the hidden one of an exp==expMax term sits at bit 11.
  function automatic int refValue(input logic sign, input logic zero, input logic [10:0] frac,
                                  input int e, input int expMax);
    int sh;
    int mag;
    if (zero) return 0;
    sh = expMax - e;
    if (sh >= 12) mag = 0;
    else mag = (2048 + int'(frac)) / (1 << sh);
    return sign ? -mag : mag;
  endfunction

  // Block max over non-zero terms (0 if none), then every expected output.
  function automatic vec_t withExpected(input vec_t v);
    vec_t r;
    int m;
    bit seen;
    r = v;
    m = 0;
    seen = 0;
    for (int k = 0; k < int'(v.n); k++) begin
      if (!v.zero[k]) begin
        int e;
        e = $signed(v.exp[k]);
        if (!seen || e > m) m = e;
        seen = 1;
      end
    end
    r.expExp = 6'(m);
    for (int k = 0; k < 4; k++) begin
      r.expData[k] = 20'(refValue(v.sign[k], v.zero[k], v.frac[k], $signed(v.exp[k]), m));
    end
    return r;
  endfunction

  task automatic applyStimulus(input vec_t v, input bit gaps);
    for (int k = 0; k < int'(v.n); k++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_sign  = v.sign[k];
      in_zero  = v.zero[k];
      in_frac  = v.frac[k];
      in_exp   = v.exp[k];
      in_last  = v.useLast && (k == int'(v.n) - 1);
      checkOutput($sformatf("in_ready before term %0d", k), 32'(in_ready), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic collectOutputs(input vec_t v, input int stallAt, input int stallLen, input bit junk);
    int waitCycles;
    waitCycles = 0;
    if (junk) begin
      in_valid = 1'b1;
      in_sign  = 1'($urandom);
      in_zero  = 1'b0;
      in_frac  = 11'($urandom);
      in_exp   = 6'd31;
      in_last  = 1'b1;
    end
    while (!out_valid && waitCycles < 10) begin
      @(posedge clk); #1;
      waitCycles++;
    end
    checkOutput("cycles to first out_valid", 32'(waitCycles), 32'd0);
    for (int k = 0; k < int'(v.n); k++) begin
      checkOutput($sformatf("out_valid term %0d", k), 32'(out_valid), 32'd1);
      checkOutput($sformatf("out_data term %0d", k), 32'(out_data), 32'(v.expData[k]));
      checkOutput($sformatf("out_exp term %0d", k), 32'(out_exp), 32'(v.expExp));
      checkOutput($sformatf("out_last term %0d", k), 32'(out_last), 32'(k == int'(v.n) - 1));
      checkOutput($sformatf("in_ready during emit term %0d", k), 32'(in_ready), 32'd0);
      if (k == stallAt && stallLen > 0) begin
        out_ready = 1'b0;
        for (int s = 0; s < stallLen; s++) begin
          @(posedge clk); #1;
          checkOutput($sformatf("stalled out_data term %0d", k), 32'(out_data), 32'(v.expData[k]));
          checkOutput($sformatf("stalled out_valid term %0d", k), 32'(out_valid), 32'd1);
          checkOutput($sformatf("stalled out_last term %0d", k), 32'(out_last), 32'(k == int'(v.n) - 1));
          checkOutput("stalled in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    checkOutput("in_ready after block", 32'(in_ready), 32'd1);
    checkOutput("out_valid after block", 32'(out_valid), 32'd0);
  endtask

  function automatic vec_t randomVec();
    vec_t v;
    v = '0;
    v.n = 3'($urandom_range(1, BLK_N));
    v.useLast = (v.n < 3'(BLK_N)) ? 1'b1 : 1'($urandom_range(0, 1));
    for (int k = 0; k < int'(v.n); k++) begin
      int e;
      v.zero[k] = ($urandom_range(0, 3) == 0);
      v.sign[k] = 1'($urandom);
      v.frac[k] = 11'($urandom);
      if ($urandom_range(0, 4) == 0) e = int'($urandom_range(0, 63)) - 32;
      else e = int'($urandom_range(0, 20)) - 10;
      v.exp[k] = 6'(e);
    end
    return withExpected(v);
  endfunction

  initial begin
    vec_t v;

    // Full block closed by count, frac=0: exps 0,-2,1,-13, signs +,-,+,+
    tbl[0] = '{n: 3'd4, useLast: 1'b0, sign: 4'b0010, zero: 4'b0000,
               frac: {11'h0, 11'h0, 11'h0, 11'h0}, exp: {6'h33, 6'd1, 6'h3E, 6'd0},
               expExp: 6'd1, expData: {20'h00000, 20'h00800, 20'hFFF00, 20'h00400}};
    // Partial block closed by in_last
    tbl[1] = '{n: 3'd2, useLast: 1'b1, sign: 4'b0010, zero: 4'b0000,
               frac: {11'h0, 11'h0, 11'h0, 11'h400}, exp: {6'd0, 6'd0, 6'd3, 6'd3},
               expExp: 6'd3, expData: {20'h0, 20'h0, 20'hFF800, 20'h00C00}};
    // Extreme fractions, equal exponents
    tbl[2] = '{n: 3'd2, useLast: 1'b1, sign: 4'b0010, zero: 4'b0000,
               frac: {11'h0, 11'h0, 11'h7FF, 11'h7FF}, exp: {6'd0, 6'd0, 6'd5, 6'd5},
               expExp: 6'd5, expData: {20'h0, 20'h0, 20'hFF001, 20'h00FFF}};
    // All-zero block: signs and exponents must be ignored
    tbl[3] = '{n: 3'd4, useLast: 1'b0, sign: 4'b0101, zero: 4'b1111,
               frac: {11'h1A5, 11'h7FF, 11'h001, 11'h300}, exp: {6'd7, 6'h30, 6'd31, 6'd2},
               expExp: 6'd0, expData: {20'h0, 20'h0, 20'h0, 20'h0}};
    // Zero term with a large exponent next to a term at -5
    tbl[4] = '{n: 3'd2, useLast: 1'b1, sign: 4'b0001, zero: 4'b0001,
               frac: {11'h0, 11'h0, 11'h0, 11'h123}, exp: {6'd0, 6'd0, 6'h3B, 6'd20},
               expExp: 6'h3B, expData: {20'h0, 20'h0, 20'h00800, 20'h0}};
    // Single-term block at the most negative exponent
    tbl[5] = '{n: 3'd1, useLast: 1'b1, sign: 4'b0001, zero: 4'b0000,
               frac: {11'h0, 11'h0, 11'h0, 11'h001}, exp: {6'd0, 6'd0, 6'd0, 6'h20},
               expExp: 6'h20, expData: {20'h0, 20'h0, 20'h0, 20'hFF7FF}};
    // Shift boundary: 11 keeps one bit, 12 flushes (negative flushes to +0)
    tbl[6] = '{n: 3'd3, useLast: 1'b1, sign: 4'b0100, zero: 4'b0000,
               frac: {11'h0, 11'h7FF, 11'h7FF, 11'h7FF}, exp: {6'd0, 6'h3F, 6'd0, 6'd11},
               expExp: 6'd11, expData: {20'h0, 20'h0, 20'h00001, 20'h00FFF}};

    // Reset values
    #12;
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset out_data", 32'(out_data), 32'd0);
    checkOutput("reset out_exp", 32'(out_exp), 32'd0);
    checkOutput("reset out_last", 32'(out_last), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table vectors; the first full block gets a 5-cycle stall mid-emit
    for (int i = 0; i < 7; i++) begin
      $display("[TB] table vector %0d", i);
      applyStimulus(tbl[i], 1'b0);
      collectOutputs(tbl[i], (i == 0) ? 1 : -1, (i == 0) ? 5 : 0, (i == 1));
    end

    // Randomized blocks against the reference model
    for (int i = 0; i < 40; i++) begin
      int sAt;
      v = randomVec();
      sAt = int'($urandom_range(0, int'(v.n) - 1));
      applyStimulus(v, 1'b1);
      collectOutputs(v, sAt, int'($urandom_range(0, 3)), 1'($urandom));
    end

    // Reset while presenting term index 1
    $display("[TB] reset during emit");
    v = randomVec();
    v.n = 3'd4;
    v.useLast = 1'b0;
    v.zero[0] = 1'b0;
    v = withExpected(v);
    applyStimulus(v, 1'b0);
    checkOutput("pre-reset out_data term 0", 32'(out_data), 32'(v.expData[0]));
    @(posedge clk); #1;
    checkOutput("pre-reset out_data term 1", 32'(out_data), 32'(v.expData[1]));
    rst_n = 1'b0;
    #1;
    checkOutput("async reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("async reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("async reset out_data", 32'(out_data), 32'd0);
    checkOutput("async reset out_exp", 32'(out_exp), 32'd0);
    checkOutput("async reset out_last", 32'(out_last), 32'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("post-reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("post-reset out_valid", 32'(out_valid), 32'd0);
    applyStimulus(tbl[1], 1'b0);
    collectOutputs(tbl[1], -1, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
